// File: rtl/bit_serializer_pkg.sv
// Shared constants for the serializer and the downstream sequence detector.
// FSM encodings live here so both blocks decode the same values.
package bit_serializer_pkg;
  localparam logic [0:0] SER_IDLE  = 1'b0;
  localparam logic [0:0] SER_SHIFT = 1'b1;

  localparam bit IDLE_BIT_DEF = 1'b0;

  // Detector state encodings, kept alongside so the two blocks stay in step
  localparam logic [1:0] DET_S0 = 2'd0;
  localparam logic [1:0] DET_S1 = 2'd1;
  localparam logic [1:0] DET_S2 = 2'd2;
  localparam logic [1:0] DET_S3 = 2'd3;
endpackage

// File: rtl/bit_serializer_if.sv
// Parallel word handshake into the serializer.
interface bit_serializer_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;

  modport master (output din, din_valid, input din_ready);
  modport slave  (input din, din_valid, output din_ready);
endinterface

// File: rtl/bit_serializer_mod_counter.sv
// Modulus-MOD counter with synchronous clear/enable; tc is high at MOD-1.
module bit_serializer_mod_counter #(
  parameter int MOD = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int W = $clog2(MOD);

  logic [W-1:0] cnt;

  assign tc = (cnt == W'(MOD - 1));

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (en)
      cnt <= tc ? '0 : cnt + W'(1);
  end
endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage feeding the sequence detector: one bit per clk,
// zero-gap between back-to-back words, IDLE_BIT otherwise.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = IDLE_BIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  bit_serializer_if.slave  in_if,
  output logic             o_bit,
  output logic             o_active,
  output logic             o_last
);
  logic [0:0]       state, state_nxt;
  logic [WIDTH-1:0] sr, sr_nxt;
  logic             tc, xfer, head_nxt;

  bit_serializer_mod_counter #(.MOD(WIDTH)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (xfer),
    .en  (state == SER_SHIFT),
    .tc  (tc)
  );

  // Ready only on the final bit of a word (or when idle) so nothing is buffered
  assign in_if.din_ready = !rst && ((state == SER_IDLE) || tc);
  assign xfer            = in_if.din_valid && in_if.din_ready;
  assign o_last          = (state == SER_SHIFT) && tc;

  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    if (xfer) begin
      state_nxt = SER_SHIFT;
      sr_nxt    = in_if.din;
    end else if (state == SER_SHIFT) begin
      sr_nxt = MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
      if (tc)
        state_nxt = SER_IDLE;
    end
    head_nxt = MSB_FIRST ? sr_nxt[WIDTH-1] : sr_nxt[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SER_IDLE;
      sr       <= '0;
      o_bit    <= IDLE_BIT;
      o_active <= 1'b0;
    end else begin
      state    <= state_nxt;
      sr       <= sr_nxt;
      o_active <= (state_nxt == SER_SHIFT);
      o_bit    <= (state_nxt == SER_SHIFT) ? head_nxt : IDLE_BIT;
    end
  end
endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench: expected serial bits are queued as words are offered
// and popped as the DUTs shift them out.
module tb_bit_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic o_bit1, o_act1, o_last1;
  logic o_bit0, o_act0, o_last0;
  logic q[$];
  logic exp_b;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  bit_serializer_if #(.WIDTH(8)) if1();
  bit_serializer_if #(.WIDTH(8)) if0();

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut1 (
    .clk(clk), .rst(rst), .in_if(if1),
    .o_bit(o_bit1), .o_active(o_act1), .o_last(o_last1)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_if(if0),
    .o_bit(o_bit0), .o_active(o_act0), .o_last(o_last0)
  );

  task automatic push_word(input logic [7:0] w, input bit msb);
    for (int i = 0; i < 8; i++) q.push_back(msb ? w[7-i] : w[i]);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if1.din = '0; if1.din_valid = 1'b0;
    if0.din = '0; if0.din_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (o_bit1 !== 1'b0) begin failures++; $display("FAIL rst_o_bit c=%0d got=%b exp=0", c, o_bit1); end
      checks++; if (o_act1 !== 1'b0) begin failures++; $display("FAIL rst_o_active c=%0d got=%b exp=0", c, o_act1); end
      checks++; if (o_last1 !== 1'b0) begin failures++; $display("FAIL rst_o_last c=%0d got=%b exp=0", c, o_last1); end
      checks++; if (if1.din_ready !== 1'b0) begin failures++; $display("FAIL rst_din_ready c=%0d got=%b exp=0", c, if1.din_ready); end
      checks++; if (if0.din_ready !== 1'b0) begin failures++; $display("FAIL rst_din_ready_lsb c=%0d got=%b exp=0", c, if0.din_ready); end
    end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (if1.din_ready !== 1'b1) begin failures++; $display("FAIL post_rst_ready got=%b exp=1", if1.din_ready); end
    checks++; if (o_act1 !== 1'b0) begin failures++; $display("FAIL post_rst_active got=%b exp=0", o_act1); end
  endtask

  task automatic test_single_msb();
    checks++; if (if1.din_ready !== 1'b1) begin failures++; $display("FAIL single_accept got=%b exp=1", if1.din_ready); end
    if1.din = 8'b1010_0000; if1.din_valid = 1'b1;
    push_word(8'b1010_0000, 1'b1);
    @(negedge clk);
    if1.din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_b = (q.size() > 0) ? q.pop_front() : 1'bx;
      checks++; if (o_bit1 !== exp_b) begin failures++; $display("FAIL single_bit i=%0d got=%b exp=%b", i, o_bit1, exp_b); end
      checks++; if (o_act1 !== 1'b1) begin failures++; $display("FAIL single_active i=%0d got=%b exp=1", i, o_act1); end
      checks++; if (o_last1 !== (i == 7)) begin failures++; $display("FAIL single_last i=%0d got=%b exp=%b", i, o_last1, (i == 7)); end
      checks++; if (if1.din_ready !== (i == 7)) begin failures++; $display("FAIL single_ready i=%0d got=%b exp=%b", i, if1.din_ready, (i == 7)); end
      @(negedge clk);
    end
    checks++; if (o_act1 !== 1'b0) begin failures++; $display("FAIL single_idle_active got=%b exp=0", o_act1); end
    checks++; if (o_bit1 !== 1'b0) begin failures++; $display("FAIL single_idle_bit got=%b exp=0", o_bit1); end
    checks++; if (o_last1 !== 1'b0) begin failures++; $display("FAIL single_idle_last got=%b exp=0", o_last1); end
  endtask

  task automatic test_back_to_back();
    if1.din = 8'hA5; if1.din_valid = 1'b1;
    push_word(8'hA5, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      exp_b = (q.size() > 0) ? q.pop_front() : 1'bx;
      checks++; if (o_bit1 !== exp_b) begin failures++; $display("FAIL b2b_bit i=%0d got=%b exp=%b", i, o_bit1, exp_b); end
      checks++; if (o_act1 !== 1'b1) begin failures++; $display("FAIL b2b_active i=%0d got=%b exp=1", i, o_act1); end
      checks++; if (if1.din_ready !== (i == 7 || i == 15)) begin failures++; $display("FAIL b2b_ready i=%0d got=%b exp=%b", i, if1.din_ready, (i == 7 || i == 15)); end
      checks++; if (o_last1 !== (i == 7 || i == 15)) begin failures++; $display("FAIL b2b_last i=%0d got=%b exp=%b", i, o_last1, (i == 7 || i == 15)); end
      if (i == 7) begin if1.din = 8'h5A; push_word(8'h5A, 1'b1); end
      if (i == 15) if1.din_valid = 1'b0;
      @(negedge clk);
    end
    checks++; if (o_act1 !== 1'b0) begin failures++; $display("FAIL b2b_idle_active got=%b exp=0", o_act1); end
    checks++; if (q.size() != 0) begin failures++; $display("FAIL b2b_queue_left got=%0d exp=0", q.size()); end
  endtask

  task automatic test_lsb_first();
    checks++; if (if0.din_ready !== 1'b1) begin failures++; $display("FAIL lsb_accept got=%b exp=1", if0.din_ready); end
    if0.din = 8'h01; if0.din_valid = 1'b1;
    push_word(8'h01, 1'b0);
    @(negedge clk);
    if0.din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_b = (q.size() > 0) ? q.pop_front() : 1'bx;
      checks++; if (o_bit0 !== exp_b) begin failures++; $display("FAIL lsb_bit i=%0d got=%b exp=%b", i, o_bit0, exp_b); end
      checks++; if (o_act0 !== 1'b1) begin failures++; $display("FAIL lsb_active i=%0d got=%b exp=1", i, o_act0); end
      checks++; if (o_last0 !== (i == 7)) begin failures++; $display("FAIL lsb_last i=%0d got=%b exp=%b", i, o_last0, (i == 7)); end
      @(negedge clk);
    end
    for (int c = 0; c < 2; c++) begin
      checks++; if (o_bit0 !== 1'b0) begin failures++; $display("FAIL lsb_idle_bit c=%0d got=%b exp=0", c, o_bit0); end
      checks++; if (o_act0 !== 1'b0) begin failures++; $display("FAIL lsb_idle_active c=%0d got=%b exp=0", c, o_act0); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_abort();
    if1.din = 8'hFF; if1.din_valid = 1'b1;
    push_word(8'hFF, 1'b1);
    @(negedge clk);
    if1.din_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_b = (q.size() > 0) ? q.pop_front() : 1'bx;
      checks++; if (o_bit1 !== exp_b) begin failures++; $display("FAIL abort_pre_bit i=%0d got=%b exp=%b", i, o_bit1, exp_b); end
      if (i == 3) rst = 1'b1;
      @(negedge clk);
    end
    checks++; if (o_bit1 !== 1'b0) begin failures++; $display("FAIL abort_bit got=%b exp=0", o_bit1); end
    checks++; if (o_act1 !== 1'b0) begin failures++; $display("FAIL abort_active got=%b exp=0", o_act1); end
    checks++; if (o_last1 !== 1'b0) begin failures++; $display("FAIL abort_last got=%b exp=0", o_last1); end
    checks++; if (if1.din_ready !== 1'b0) begin failures++; $display("FAIL abort_ready got=%b exp=0", if1.din_ready); end
    rst = 1'b0;
    q.delete();
    @(negedge clk);
    checks++; if (o_act1 !== 1'b0) begin failures++; $display("FAIL abort_no_resume got=%b exp=0", o_act1); end
    checks++; if (if1.din_ready !== 1'b1) begin failures++; $display("FAIL abort_ready_after got=%b exp=1", if1.din_ready); end
    if1.din = 8'h81; if1.din_valid = 1'b1;
    push_word(8'h81, 1'b1);
    @(negedge clk);
    if1.din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_b = (q.size() > 0) ? q.pop_front() : 1'bx;
      checks++; if (o_bit1 !== exp_b) begin failures++; $display("FAIL abort_next_bit i=%0d got=%b exp=%b", i, o_bit1, exp_b); end
      checks++; if (o_act1 !== 1'b1) begin failures++; $display("FAIL abort_next_active i=%0d got=%b exp=1", i, o_act1); end
      @(negedge clk);
    end
    checks++; if (o_act1 !== 1'b0) begin failures++; $display("FAIL abort_next_idle got=%b exp=0", o_act1); end
  endtask

  task automatic test_ignore_busy();
    if1.din = 8'hC3; if1.din_valid = 1'b1;
    push_word(8'hC3, 1'b1);
    @(negedge clk);
    if1.din_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_b = (q.size() > 0) ? q.pop_front() : 1'bx;
      checks++; if (o_bit1 !== exp_b) begin failures++; $display("FAIL ignore_bit i=%0d got=%b exp=%b", i, o_bit1, exp_b); end
      checks++; if (o_act1 !== 1'b1) begin failures++; $display("FAIL ignore_active i=%0d got=%b exp=1", i, o_act1); end
      checks++; if (if1.din_ready !== (i == 7 || i == 15)) begin failures++; $display("FAIL ignore_ready i=%0d got=%b exp=%b", i, if1.din_ready, (i == 7 || i == 15)); end
      if (i >= 1 && i <= 5) begin
        if1.din       = 8'($urandom);
        if1.din_valid = (i % 2) == 1;
      end
      if (i == 6) if1.din_valid = 1'b0;
      if (i == 7) begin if1.din = 8'h96; if1.din_valid = 1'b1; push_word(8'h96, 1'b1); end
      if (i == 8) begin if1.din = 8'h00; if1.din_valid = 1'b0; end
      @(negedge clk);
    end
    checks++; if (o_act1 !== 1'b0) begin failures++; $display("FAIL ignore_idle_active got=%b exp=0", o_act1); end
    checks++; if (q.size() != 0) begin failures++; $display("FAIL ignore_queue_left got=%0d exp=0", q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_msb();
    test_back_to_back();
    test_lsb_first();
    test_reset_abort();
    test_ignore_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
